// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects the game buttons and captures a range-checked BCD guess.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start_button,
    input  logic       Guess_button,
    input  logic [9:0] switch,
    output logic       start_pulse,
    output logic       guess_pulse,
    output logic       guess_reject,
    output logic       guess_neg,
    output logic [3:0] guess_tens,
    output logic [3:0] guess_ones,
    output logic [9:0] sw_sync
);
    localparam logic [1:0]       IDLE = {2{BTN_ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Button vectors are indexed 0 = start, 1 = guess; db_q holds 1 = pressed.
    logic [1:0]       b1_q, b2_q, db_q, db_d, rise_q, rise_d;
    logic [9:0]       sw1_q, sw2_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             legal, start_d, guess_d, reject_d;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if ((b2_q[i] ^ BTN_ACTIVE_LOW) != db_q[i]) begin
                if (cnt_q[i] == LAST) db_d[i] = ~db_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise_d   = db_d & ~db_q;
        legal    = (sw2_q[7:4] <= 4'd9) && (sw2_q[3:0] <= 4'd9);
        start_d  = rise_q[0];
        // A guess press landing together with a start press is swallowed.
        guess_d  = rise_q[1] & ~rise_q[0] & legal;
        reject_d = rise_q[1] & ~rise_q[0] & ~legal;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            b1_q         <= IDLE;
            b2_q         <= IDLE;
            sw1_q        <= '0;
            sw2_q        <= '0;
            db_q         <= '0;
            rise_q       <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            start_pulse  <= 1'b0;
            guess_pulse  <= 1'b0;
            guess_reject <= 1'b0;
            guess_neg    <= 1'b0;
            guess_tens   <= '0;
            guess_ones   <= '0;
        end else begin
            b1_q         <= {Guess_button, Start_button};
            b2_q         <= b1_q;
            sw1_q        <= switch;
            sw2_q        <= sw1_q;
            db_q         <= db_d;
            rise_q       <= rise_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            start_pulse  <= start_d;
            guess_pulse  <= guess_d;
            guess_reject <= reject_d;
            if (guess_d) begin
                guess_neg  <= sw2_q[9];
                guess_tens <= sw2_q[7:4];
                guess_ones <= sw2_q[3:0];
            end
        end
    end
    assign sw_sync = sw2_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of sync, debounce, pulse and guess capture with DEBOUNCE_CYCLES=4.
module tb_input_conditioner;
    logic       Clock = 1'b0, Reset = 1'b1, Start_button = 1'b1, Guess_button = 1'b1;
    logic [9:0] switch = '0;
    logic       start_pulse, guess_pulse, guess_reject, guess_neg;
    logic [3:0] guess_tens, guess_ones;
    logic [9:0] sw_sync;
    int n_cmp = 0, n_bad = 0, sp = 0, gp = 0, gr = 0, excl = 0, lat = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .BTN_ACTIVE_LOW(1)) dut (
        .Clock(Clock), .Reset(Reset), .Start_button(Start_button), .Guess_button(Guess_button),
        .switch(switch), .start_pulse(start_pulse), .guess_pulse(guess_pulse),
        .guess_reject(guess_reject), .guess_neg(guess_neg), .guess_tens(guess_tens),
        .guess_ones(guess_ones), .sw_sync(sw_sync)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            sp += int'(start_pulse);
            gp += int'(guess_pulse);
            gr += int'(guess_reject);
            if (int'(start_pulse) + int'(guess_pulse) + int'(guess_reject) > 1) excl++;
        end
    endtask

    // Counts edges until the chosen pulse is seen; 99 means it never came.
    task automatic wait_pulse(input bit use_guess, output int edges);
        edges = 99;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (use_guess ? guess_pulse : start_pulse) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic clear_counts();
        sp = 0; gp = 0; gr = 0;
    endtask

    initial begin
        step(2);
        Reset = 1'b0;
        check("rst_start", start_pulse, 0);
        check("rst_guess", guess_pulse, 0);
        check("rst_reject", guess_reject, 0);
        check("rst_neg", guess_neg, 0);
        check("rst_tens", guess_tens, 0);
        check("rst_ones", guess_ones, 0);
        check("rst_sw", sw_sync, 0);
        clear_counts();
        step(50);
        check("idle_pulses", sp + gp + gr, 0);

        Guess_button = 1'b0;
        step(3);
        Guess_button = 1'b1;
        step(20);
        check("glitch_no_pulse", gp, 0);
        clear_counts();
        Guess_button = 1'b0;
        wait_pulse(1'b1, lat);
        check("guess_latency", lat, 7);
        step(20);
        check("guess_once", gp, 1);
        Guess_button = 1'b1;
        step(10);

        switch = 10'b1_0_0100_0111;
        step(3);
        check("sw_sync", sw_sync, 10'b1_0_0100_0111);
        clear_counts();
        Guess_button = 1'b0;
        step(10);
        Guess_button = 1'b1;
        step(10);
        check("legal_pulse", gp, 1);
        check("legal_no_reject", gr, 0);
        check("cap_neg", guess_neg, 1);
        check("cap_tens", guess_tens, 4);
        check("cap_ones", guess_ones, 7);

        switch = 10'b0_0_1010_0011;
        step(3);
        clear_counts();
        Guess_button = 1'b0;
        step(10);
        Guess_button = 1'b1;
        step(10);
        check("illegal_reject", gr, 1);
        check("illegal_no_pulse", gp, 0);
        check("hold_neg", guess_neg, 1);
        check("hold_tens", guess_tens, 4);
        check("hold_ones", guess_ones, 7);

        switch = 10'b0_0_0001_0010;
        step(3);
        clear_counts();
        Start_button = 1'b0;
        Guess_button = 1'b0;
        step(12);
        check("both_start", sp, 1);
        check("both_no_guess", gp + gr, 0);
        step(20);
        check("held_no_guess", gp + gr, 0);
        check("both_no_capture", guess_tens, 4);
        Start_button = 1'b1;
        Guess_button = 1'b1;
        step(10);
        check("release_no_pulse", sp + gp + gr, 1);

        clear_counts();
        Start_button = 1'b0;
        step(4);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        wait_pulse(1'b0, lat);
        check("reset_latency", lat, 7);
        step(20);
        check("reset_one_pulse", sp, 1);
        Start_button = 1'b1;
        step(10);
        check("mutual_excl", excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
